wfifo_cap_ctrl: RTL and testbench
=================================

WFIFO_CAP_CTRL -- requirements
Module: wfifo_cap_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, ADC sample width.
REQ-002 SHALL have parameter PACK, default 4, samples packed per FIFO word; FIFO_DW = SAMPLE_W*PACK (32).
REQ-003 SHALL have parameter CAP_WORDS, default 256, words per capture; counter width CNT_W = clog2(CAP_WORDS)+1.
REQ-004 SHALL have port clk  in  1  single clock (FIFO write clock); all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port arm  in  1  one-cycle start-capture request.
REQ-007 SHALL have port abort  in  1  cancel current capture.
REQ-008 SHALL have port force_trig  in  1  immediate software trigger.
REQ-009 SHALL have port trig_edge  in  1  0 = rising, 1 = falling.
REQ-010 SHALL have port trig_level  in  SAMPLE_W  trigger threshold, unsigned.
REQ-011 SHALL have port decim  in  16  keep one of every decim+1 valid samples.
REQ-012 SHALL have port adc_data  in  SAMPLE_W  ADC sample.
REQ-013 SHALL have port adc_valid  in  1  adc_data qualifier.
REQ-014 SHALL have port fifo_wr_data  out  FIFO_DW  packed word to wfifo wr_data.
REQ-015 SHALL have port fifo_wr_en  out  1  one-cycle write strobe to wfifo wr_en.
REQ-016 SHALL have port fifo_full  in  1  from wfifo wr_full.
REQ-017 SHALL have port fifo_almost_full  in  1  from wfifo almost_full.
REQ-018 SHALL have port busy  out  1  high in ARMED or CAPTURE.
REQ-019 SHALL have port done  out  1  one-cycle capture-complete pulse.
REQ-020 SHALL have port overflow  out  1  sticky: a word was dropped on fifo_full.
REQ-021 SHALL have port word_cnt  out  CNT_W  words completed in current/last capture.

Function
REQ-022 SHALL implement states IDLE, ARMED, CAPTURE; IDLE->ARMED on arm with fifo_almost_full low; arm while fifo_almost_full high is ignored.
REQ-023 SHALL ignore arm outside IDLE; on accepted arm clear overflow, word_cnt, decimation counter, packing lane, prev-sample-valid.
REQ-024 SHALL take a sample when adc_valid and dec_cnt == decim, then dec_cnt <= 0; otherwise dec_cnt increments on adc_valid; decim = 0 takes every valid sample.
REQ-025 SHALL, in ARMED, use the first taken sample only to load prev; thereafter rising trigger = prev < trig_level and cur >= trig_level; falling = prev > trig_level and cur <= trig_level.
REQ-026 SHALL on trigger enter CAPTURE with the triggering sample packed into lane 0; on force_trig in ARMED enter CAPTURE next cycle and pack from the next taken sample.
REQ-027 SHALL pack lanes little-endian (lane 0 = bits SAMPLE_W-1:0); after lane PACK-1 fills, assert fifo_wr_en for exactly one cycle on the next clock with the registered word.
REQ-028 SHALL, if fifo_full is high when a word completes, suppress fifo_wr_en, set overflow, still increment word_cnt (fixed capture duration).
REQ-029 SHALL after word CAP_WORDS completes return to IDLE, pulse done in the same cycle as that word's fifo_wr_en (or its suppressed slot).
REQ-030 SHALL on abort in any state go to IDLE next cycle, discard the partial word, no write, no done; abort wins over simultaneous arm or trigger.
REQ-031 SHALL keep fifo_wr_en low in IDLE and ARMED; word_cnt saturates at CAP_WORDS.

Reset
REQ-032 SHALL on rst_n low at a clock edge set state IDLE and all outputs, counters, lanes and prev registers to 0; a reset mid-capture discards the partial word without a write.

Structure
REQ-033 SHALL place the state encoding, trig-edge constants and SAMPLE_W/PACK/CAP_WORDS defaults in shared package wfifo_cap_pkg.
REQ-034 SHALL instantiate one sub-module wfifo_trig_detect (prev register, prev-valid, edge comparators).

Verification
REQ-035 SHALL cover: decim=0, level=0x80, rising, ramp 0x7E,0x7F,0x80,... -> trigger on 0x80, first word 0x83828180, 256 writes, done with last write.
REQ-036 SHALL cover: decim=2, ramp 0x00 upward, level 0x10 rising -> trigger on 0x12, first word 0x1B181512.
REQ-037 SHALL cover: fifo_full held high for words 10-12 -> 3 writes suppressed, overflow=1, word_cnt=256, done still pulses.
REQ-038 SHALL cover: abort after 2 samples of a word in CAPTURE -> IDLE next cycle, no fifo_wr_en, no done, busy=0.
REQ-039 SHALL cover: arm with fifo_almost_full=1 -> stays IDLE; force_trig in ARMED -> CAPTURE next cycle, lane 0 = next taken sample.

Source files
------------

// File: rtl/wfifo_cap_pkg.sv
// Shared types and defaults for the waveform capture controller.
// Capture FSM encoding, trigger-edge selectors and size defaults.
package wfifo_cap_pkg;

    localparam int SAMPLE_W_DEF  = 8;
    localparam int PACK_DEF      = 4;
    localparam int CAP_WORDS_DEF = 256;

    localparam logic TRIG_RISE = 1'b0;
    localparam logic TRIG_FALL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/wfifo_trig_detect.sv
// Level-crossing trigger detector for the capture controller.
// Holds the previous taken sample and flags rising/falling crossings.
module wfifo_trig_detect
    import wfifo_cap_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                trig_edge,
    input  logic [SAMPLE_W-1:0] level,
    input  logic [SAMPLE_W-1:0] cur,
    output logic                hit
);

    logic [SAMPLE_W-1:0] prev_q;
    logic [SAMPLE_W-1:0] prev_d;
    logic                prev_vld_q;
    logic                prev_vld_d;
    logic                rise;
    logic                fall;

    // First taken sample only primes prev; crossings need a valid prev.
    always_comb begin
        rise       = (prev_q < level) && (cur >= level);
        fall       = (prev_q > level) && (cur <= level);
        hit        = en && prev_vld_q &&
                     ((trig_edge == TRIG_FALL) ? fall : rise);
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (clr) begin
            prev_d     = '0;
            prev_vld_d = 1'b0;
        end else if (en) begin
            prev_d     = cur;
            prev_vld_d = 1'b1;
        end
    end

    // Previous-sample registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end

endmodule

// File: rtl/wfifo_cap_ctrl.sv
// Triggered ADC capture: decimate, trigger, pack samples into FIFO words.
// Fixed-length capture; words dropped on fifo_full still count.
module wfifo_cap_ctrl
    import wfifo_cap_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int PACK      = PACK_DEF,
    parameter int CAP_WORDS = CAP_WORDS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arm,
    input  logic                       abort,
    input  logic                       force_trig,
    input  logic                       trig_edge,
    input  logic [SAMPLE_W-1:0]        trig_level,
    input  logic [15:0]                decim,
    input  logic [SAMPLE_W-1:0]        adc_data,
    input  logic                       adc_valid,
    output logic [SAMPLE_W*PACK-1:0]   fifo_wr_data,
    output logic                       fifo_wr_en,
    input  logic                       fifo_full,
    input  logic                       fifo_almost_full,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [$clog2(CAP_WORDS):0] word_cnt
);

    localparam int FIFO_DW = SAMPLE_W * PACK;
    localparam int CNT_W   = $clog2(CAP_WORDS) + 1;
    localparam int LANE_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CNT_W-1:0]  CAP_CNT   = CNT_W'(CAP_WORDS);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CAP_WORDS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

    cap_state_e          state_q, state_d;
    logic [15:0]         dec_cnt_q, dec_cnt_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [FIFO_DW-1:0]  pack_q, pack_d;
    logic [FIFO_DW-1:0]  wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                busy_q, busy_d;
    logic                take;
    logic                trig_en;
    logic                trig_clr;
    logic                trig_hit;

    assign take    = adc_valid && (dec_cnt_q == decim);
    assign trig_en = (state_q == ST_ARMED) && take;

    wfifo_trig_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_trig (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (trig_clr),
        .en        (trig_en),
        .trig_edge (trig_edge),
        .level     (trig_level),
        .cur       (adc_data),
        .hit       (trig_hit)
    );

    // Next-state: arm, trigger, packing, word completion; abort overrides.
    always_comb begin
        state_d    = state_q;
        dec_cnt_d  = dec_cnt_q;
        lane_d     = lane_q;
        pack_d     = pack_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        word_cnt_d = word_cnt_q;
        trig_clr   = 1'b0;

        if (state_q != ST_IDLE && adc_valid) begin
            dec_cnt_d = take ? 16'd0 : dec_cnt_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (arm && !fifo_almost_full) begin
                    state_d    = ST_ARMED;
                    dec_cnt_d  = '0;
                    lane_d     = '0;
                    pack_d     = '0;
                    ovf_d      = 1'b0;
                    word_cnt_d = '0;
                    trig_clr   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (trig_hit) begin
                    state_d                = ST_CAPTURE;
                    pack_d                 = '0;
                    pack_d[SAMPLE_W-1:0]   = adc_data;
                    lane_d                 = LANE_W'(1);
                end else if (force_trig) begin
                    state_d = ST_CAPTURE;
                    pack_d  = '0;
                    lane_d  = '0;
                end
            end
            ST_CAPTURE: begin
                if (take) begin
                    pack_d[int'(lane_q)*SAMPLE_W +: SAMPLE_W] = adc_data;
                    if (lane_q == LAST_LANE) begin
                        lane_d    = '0;
                        wr_data_d = pack_d;
                        wr_en_d   = !fifo_full;
                        ovf_d     = ovf_q | fifo_full;
                        if (word_cnt_q != CAP_CNT) begin
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                        end
                        if (word_cnt_q == LAST_CNT) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            lane_d     = '0;
            pack_d     = '0;
            wr_data_d  = wr_data_q;
            wr_en_d    = 1'b0;
            done_d     = 1'b0;
            ovf_d      = ovf_q;
            word_cnt_d = word_cnt_q;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dec_cnt_q  <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            word_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dec_cnt_q  <= dec_cnt_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            word_cnt_q <= word_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_wr_data = wr_data_q;
    assign fifo_wr_en   = wr_en_q;
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign word_cnt     = word_cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_wfifo_cap_ctrl.sv
// Self-checking bench for wfifo_cap_ctrl.
// Behavioural sample-queue model plus directed and random scenarios.
module tb_wfifo_cap_ctrl;

    localparam int CW = 256;
    localparam int PK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        force_trig = 1'b0;
    logic        trig_edge = 1'b0;
    logic [7:0]  trig_level = '0;
    logic [15:0] decim = '0;
    logic [7:0]  adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_almost_full = 1'b0;
    logic [31:0] fifo_wr_data;
    logic        fifo_wr_en;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [8:0]  word_cnt;

    wfifo_cap_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .arm              (arm),
        .abort            (abort),
        .force_trig       (force_trig),
        .trig_edge        (trig_edge),
        .trig_level       (trig_level),
        .decim            (decim),
        .adc_data         (adc_data),
        .adc_valid        (adc_valid),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow),
        .word_cnt         (word_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    // reference model: 0 idle, 1 armed, 2 capture
    int         m_mode = 0;
    int         m_n = 0;
    int         m_words = 0;
    bit         m_have_prev = 0;
    logic [7:0] m_prev = '0;
    bit         m_ovf = 0;
    logic [7:0] m_q[$];
    bit         e_wr_en = 0;
    bit         e_done = 0;
    bit         e_busy = 0;
    bit         e_dchk = 0;
    logic [31:0] e_data = '0;

    function automatic logic [31:0] assemble();
        logic [31:0] w = '0;
        for (int i = 0; i < PK; i++) w |= 32'(m_q[i]) << (8 * i);
        return w;
    endfunction

    task automatic model_step();
        bit tk;
        bit hit;
        e_wr_en = 0;
        e_done  = 0;
        e_dchk  = 0;
        if (!rst_n) begin
            m_mode = 0; m_n = 0; m_words = 0; m_have_prev = 0;
            m_prev = '0; m_ovf = 0; m_q.delete();
            e_busy = 0; e_dchk = 1; e_data = '0;
            return;
        end
        if (abort) begin
            m_mode = 0;
            m_q.delete();
            e_busy = 0;
            return;
        end
        if (m_mode == 0) begin
            if (arm && !fifo_almost_full) begin
                m_mode = 1; m_n = 0; m_have_prev = 0; m_prev = '0;
                m_q.delete(); m_words = 0; m_ovf = 0;
            end
        end else begin
            tk = adc_valid && ((m_n % (int'(decim) + 1)) == int'(decim));
            if (adc_valid) m_n++;
            if (m_mode == 1) begin
                hit = 0;
                if (tk) begin
                    if (m_have_prev) begin
                        if (trig_edge)
                            hit = (m_prev > trig_level) &&
                                  (adc_data <= trig_level);
                        else
                            hit = (m_prev < trig_level) &&
                                  (adc_data >= trig_level);
                    end
                    m_have_prev = 1;
                    m_prev = adc_data;
                end
                if (hit) begin
                    m_mode = 2;
                    m_q.delete();
                    m_q.push_back(adc_data);
                end else if (force_trig) begin
                    m_mode = 2;
                    m_q.delete();
                end
            end else if (tk) begin
                m_q.push_back(adc_data);
                if (m_q.size() == PK) begin
                    e_data = assemble();
                    m_q.delete();
                    if (fifo_full) m_ovf = 1;
                    else begin e_wr_en = 1; e_dchk = 1; end
                    m_words++;
                    if (m_words == CW) begin
                        e_done = 1;
                        m_mode = 0;
                    end
                end
            end
        end
        e_busy = (m_mode != 0);
    endtask

    int          n_wr = 0;
    int          n_done = 0;
    bit          got_first = 0;
    bit          done_wr = 0;
    logic [31:0] first_word = '0;

    task automatic clr_trk();
        n_wr = 0; n_done = 0; got_first = 0; done_wr = 0;
        first_word = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("wr_en", fifo_wr_en, e_wr_en);
        chk("done", done, e_done);
        chk("busy", busy, e_busy);
        chk("overflow", overflow, m_ovf);
        chk("word_cnt", word_cnt, m_words);
        if (e_dchk) chk("wr_data", fifo_wr_data, e_data);
        if (fifo_wr_en) begin
            n_wr++;
            if (!got_first) begin
                got_first = 1;
                first_word = fifo_wr_data;
            end
        end
        if (done) begin
            n_done++;
            done_wr = fifo_wr_en;
        end
    endtask

    task automatic quiet();
        arm = 0; abort = 0; force_trig = 0; adc_valid = 0;
        fifo_full = 0; fifo_almost_full = 0;
    endtask

    initial begin
        logic [7:0] v;
        bit fin;

        // reset state
        rst_n = 0;
        tick();
        tick();
        chk("rst_data", fifo_wr_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1;
        tick();

        // decim 0, rising through 0x80
        clr_trk();
        decim = 0; trig_level = 8'h80; trig_edge = 0;
        v = 8'h7E; arm = 1; adc_valid = 1; adc_data = v;
        tick();
        arm = 0;
        fin = 0;
        for (int i = 0; i < 1100 && !fin; i++) begin
            v++; adc_data = v;
            tick();
            if (done) fin = 1;
        end
        chk("s1_done_seen", fin, 1'b1);
        chk("s1_first", first_word, 32'h83828180);
        chk("s1_writes", n_wr, CW);
        chk("s1_done_wr", done_wr, 1'b1);
        chk("s1_cnt", word_cnt, CW);
        quiet();
        tick();

        // decim 2, ramp from 0, level 0x10 rising
        clr_trk();
        decim = 2; trig_level = 8'h10; trig_edge = 0;
        v = 8'h00; arm = 1; adc_valid = 1; adc_data = v;
        tick();
        arm = 0;
        fin = 0;
        for (int i = 0; i < 3200 && !fin; i++) begin
            v++; adc_data = v;
            tick();
            if (done) fin = 1;
        end
        chk("s2_done_seen", fin, 1'b1);
        chk("s2_first", first_word, 32'h1B181512);
        quiet();
        tick();

        // fifo_full during words 10..12
        clr_trk();
        decim = 0;
        arm = 1;
        tick();
        arm = 0; force_trig = 1;
        tick();
        force_trig = 0;
        fin = 0;
        for (int i = 0; i < 1100 && !fin; i++) begin
            adc_valid = 1;
            adc_data = 8'($urandom);
            fifo_full = (m_words >= 9 && m_words <= 11);
            tick();
            if (done) fin = 1;
        end
        chk("s3_done_seen", fin, 1'b1);
        chk("s3_writes", n_wr, CW - 3);
        chk("s3_ovf", overflow, 1'b1);
        chk("s3_cnt", word_cnt, CW);
        quiet();
        tick();

        // abort two samples into the second word
        clr_trk();
        arm = 1;
        tick();
        arm = 0; force_trig = 1;
        tick();
        force_trig = 0;
        for (int i = 0; i < 6; i++) begin
            adc_valid = 1; adc_data = 8'(8'h40 + i);
            tick();
        end
        abort = 1; adc_data = 8'h50;
        tick();
        abort = 0;
        chk("s4_busy", busy, 1'b0);
        chk("s4_wr_en", fifo_wr_en, 1'b0);
        chk("s4_done", done, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("s4_writes", n_wr, 1);
        chk("s4_ndone", n_done, 0);
        quiet();

        // arm blocked by almost_full, then force trigger
        clr_trk();
        trig_level = 8'h00; trig_edge = 0;
        fifo_almost_full = 1; arm = 1;
        tick();
        arm = 0; fifo_almost_full = 0;
        chk("s5_blocked", busy, 1'b0);
        tick();
        arm = 1;
        tick();
        arm = 0;
        chk("s5_armed", busy, 1'b1);
        adc_valid = 1; adc_data = 8'h11;
        tick();
        adc_data = 8'h22;
        tick();
        force_trig = 1; adc_data = 8'h33;
        tick();
        force_trig = 0;
        for (int i = 1; i <= 4; i++) begin
            adc_data = 8'(8'hA0 + i);
            tick();
        end
        chk("s5_first", first_word, 32'hA4A3A2A1);
        abort = 1;
        tick();
        quiet();
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 8000; i++) begin
            if (m_mode == 0) begin
                decim = 16'($urandom_range(0, 3));
                trig_level = 8'($urandom);
                trig_edge = 1'($urandom);
            end
            arm = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 299) == 0);
            force_trig = ($urandom_range(0, 49) == 0);
            adc_valid = ($urandom_range(0, 9) < 7);
            adc_data = 8'($urandom);
            fifo_full = ($urandom_range(0, 9) == 0);
            fifo_almost_full = ($urandom_range(0, 7) == 0);
            tick();
        end

        // reset mid-capture
        quiet();
        decim = 0;
        arm = 1;
        tick();
        arm = 0; force_trig = 1;
        tick();
        force_trig = 0; adc_valid = 1; adc_data = 8'h5A;
        tick();
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        quiet();
        tick();
        chk("s7_busy", busy, 1'b0);
        chk("s7_cnt", word_cnt, 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
